// File: rtl/if_stage.sv
// Instruction fetch stage: PC generation, credit-limited imem requests, fetch buffer toward ID,
// and EX redirect handling that squashes buffered and in-flight words.

module if_stage_chk #(
    parameter int FIFO_DEPTH = 2,
    parameter int CW         = 2
) (
    input logic          clk,
    input logic          rst,
    input logic          imem_rsp_valid,
    input logic [CW-1:0] inflight,
    input logic [CW-1:0] drop,
    input logic [CW-1:0] count
);
    a_rsp_needs_inflight: assert property (@(posedge clk) disable iff (rst)
        imem_rsp_valid |-> (inflight != {CW{1'b0}}));

    a_credit_bounds: assert property (@(posedge clk) disable iff (rst)
        (({1'b0, inflight} + {1'b0, count}) <= (CW+1)'(FIFO_DEPTH)) && (drop <= inflight));
endmodule

module if_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2,
    parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_en,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_inst,
    output logic [31:0] id_pc
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    logic [31:0]   pc_r;
    logic [31:0]   rsp_pc_r;
    logic [31:0]   last_pc_r;
    logic [CW-1:0] inflight_r;
    logic [CW-1:0] drop_r;
    logic [CW-1:0] count_r;
    logic [PW-1:0] rd_ptr_r;
    logic [PW-1:0] wr_ptr_r;
    logic [31:0]   fifo_pc_r   [FIFO_DEPTH];
    logic [31:0]   fifo_inst_r [FIFO_DEPTH];

    logic [CW:0]   used_s;
    logic          credit_s;
    logic          req_fire_s;
    logic          drop_s;
    logic          push_s;
    logic          pop_s;
    logic          not_empty_s;
    logic [31:0]   target_s;
    logic          unused_ok_s;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? {PW{1'b0}} : (p + PW'(1'b1));
    endfunction

    // Credit check and per-cycle handshake decodes
    always_comb begin
        used_s      = {1'b0, inflight_r} + {1'b0, count_r};
        credit_s    = (used_s < (CW+1)'(FIFO_DEPTH));
        not_empty_s = (count_r != {CW{1'b0}});
        req_fire_s  = imem_req_valid && imem_req_ready;
        drop_s      = imem_rsp_valid && (drop_r != {CW{1'b0}});
        push_s      = imem_rsp_valid && (drop_r == {CW{1'b0}});
        pop_s       = not_empty_s && id_ready;
        target_s    = {redirect_pc[31:2], 2'b00};
        unused_ok_s = ^redirect_pc[1:0];
    end

    // Output drive: request is combinational, ID side shows the buffer head
    always_comb begin
        imem_req_valid = !rst && !redirect_en && credit_s;
        imem_req_addr  = pc_r;
        id_valid       = not_empty_s;
        if (not_empty_s) begin
            id_inst = fifo_inst_r[rd_ptr_r];
            id_pc   = fifo_pc_r[rd_ptr_r];
        end else begin
            id_inst = NOP_INST;
            id_pc   = last_pc_r;
        end
    end

    // Fetch state: PCs, credit counters and fetch buffer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_r       <= RESET_PC;
            rsp_pc_r   <= RESET_PC;
            last_pc_r  <= RESET_PC;
            inflight_r <= {CW{1'b0}};
            drop_r     <= {CW{1'b0}};
            count_r    <= {CW{1'b0}};
            rd_ptr_r   <= {PW{1'b0}};
            wr_ptr_r   <= {PW{1'b0}};
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_pc_r[i]   <= RESET_PC;
                fifo_inst_r[i] <= NOP_INST;
            end
        end else begin
            if (not_empty_s) begin
                last_pc_r <= fifo_pc_r[rd_ptr_r];
            end else begin
                last_pc_r <= last_pc_r;
            end
            if (redirect_en) begin
                pc_r       <= target_s;
                rsp_pc_r   <= target_s;
                count_r    <= {CW{1'b0}};
                rd_ptr_r   <= {PW{1'b0}};
                wr_ptr_r   <= {PW{1'b0}};
                inflight_r <= inflight_r - CW'(imem_rsp_valid);
                // Every request still outstanding after this cycle predates the redirect,
                // so the drop count becomes exactly the remaining in-flight count.
                drop_r     <= inflight_r - CW'(imem_rsp_valid);
            end else begin
                if (req_fire_s) begin
                    pc_r <= pc_r + 32'd4;
                end else begin
                    pc_r <= pc_r;
                end
                inflight_r <= inflight_r + CW'(req_fire_s) - CW'(imem_rsp_valid);
                if (drop_s) begin
                    drop_r <= drop_r - CW'(1'b1);
                end else begin
                    drop_r <= drop_r;
                end
                if (push_s) begin
                    fifo_pc_r[wr_ptr_r]   <= rsp_pc_r;
                    fifo_inst_r[wr_ptr_r] <= imem_rsp_data;
                    wr_ptr_r              <= ptr_next(wr_ptr_r);
                    rsp_pc_r              <= rsp_pc_r + 32'd4;
                end else begin
                    wr_ptr_r <= wr_ptr_r;
                    rsp_pc_r <= rsp_pc_r;
                end
                if (pop_s) begin
                    rd_ptr_r <= ptr_next(rd_ptr_r);
                end else begin
                    rd_ptr_r <= rd_ptr_r;
                end
                count_r <= count_r + CW'(push_s) - CW'(pop_s);
            end
        end
    end

    if_stage_chk #(.FIFO_DEPTH(FIFO_DEPTH), .CW(CW)) u_chk (
        .clk            (clk),
        .rst            (rst),
        .imem_rsp_valid (imem_rsp_valid),
        .inflight       (inflight_r),
        .drop           (drop_r),
        .count          (count_r)
    );
endmodule

// File: tb/tb_if_stage.sv
// Randomized bench for if_stage: an in-order memory model plus a queue-based reference of
// outstanding requests and buffered words; a second instance covers PC wrap-around.

module tb_if_stage;
    localparam int          DEPTH = 2;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    typedef struct {
        logic [31:0] addr;
        int          due;
        bit          dead;
    } req_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data  = 32'h0;
    logic        redirect_en    = 1'b0;
    logic [31:0] redirect_pc    = 32'h0;
    logic        id_valid;
    logic        id_ready = 1'b0;
    logic [31:0] id_inst;
    logic [31:0] id_pc;

    logic        w_req_valid;
    logic        w_req_ready = 1'b0;
    logic [31:0] w_req_addr;
    logic        w_rsp_valid = 1'b0;
    logic [31:0] w_rsp_data  = 32'h0;
    logic        w_id_valid;
    logic [31:0] w_id_inst;
    logic [31:0] w_id_pc;

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    int          lat, p_ready, p_rsp, p_idr, p_redir;
    bit          redir_once, redir_on_rsp, redir_hit;
    logic [31:0] redir_once_pc;
    logic [31:0] key, model_pc, last_pc;
    int          dir_cap;
    logic [31:0] dir_exp;
    bit          w_on, w_fire_prev;
    logic [31:0] w_addr_prev;
    int          w_seen;
    logic [31:0] w_exp [3];
    req_t        pend [$];
    ent_t        bufq [$];

    always #5 clk = ~clk;

    if_stage #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(DEPTH), .NOP_INST(NOP)) u_dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_en(redirect_en), .redirect_pc(redirect_pc),
        .id_valid(id_valid), .id_ready(id_ready), .id_inst(id_inst), .id_pc(id_pc)
    );

    if_stage #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(DEPTH), .NOP_INST(NOP)) u_dut_wrap (
        .clk(clk), .rst(rst),
        .imem_req_valid(w_req_valid), .imem_req_ready(w_req_ready), .imem_req_addr(w_req_addr),
        .imem_rsp_valid(w_rsp_valid), .imem_rsp_data(w_rsp_data),
        .redirect_en(1'b0), .redirect_pc(32'h0000_0000),
        .id_valid(w_id_valid), .id_ready(1'b1), .id_inst(w_id_inst), .id_pc(w_id_pc)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock cycle: drive inputs, compare against the reference, advance the reference.
    task automatic cycle();
        bit          rsp_now, e_rv, e_iv, fire, popd;
        logic [31:0] e_pc, e_inst;
        req_t        e;
        rsp_now = 1'b0;
        if (pend.size() > 0) begin
            if (pend[0].due <= cyc && $urandom_range(99) < p_rsp) rsp_now = 1'b1;
        end
        imem_rsp_valid = rsp_now;
        imem_rsp_data  = rsp_now ? (pend[0].addr ^ key) : 32'h0;
        imem_req_ready = ($urandom_range(99) < p_ready);
        id_ready       = ($urandom_range(99) < p_idr);
        redirect_en    = 1'b0;
        redirect_pc    = $urandom;
        if (redir_once) begin
            redirect_en = 1'b1;
            redirect_pc = redir_once_pc;
            redir_once  = 1'b0;
        end else if (redir_on_rsp && rsp_now && bufq.size() > 0) begin
            redirect_en  = 1'b1;
            id_ready     = 1'b1;
            redir_on_rsp = 1'b0;
            redir_hit    = 1'b1;
        end else if ($urandom_range(99) < p_redir) begin
            redirect_en = 1'b1;
        end
        w_rsp_valid = w_on && w_fire_prev;
        w_rsp_data  = w_addr_prev;
        w_req_ready = w_on;
        #1;
        e_rv   = !redirect_en && ((pend.size() + bufq.size()) < DEPTH);
        e_iv   = (bufq.size() > 0);
        e_pc   = e_iv ? bufq[0].pc : last_pc;
        e_inst = e_iv ? bufq[0].inst : NOP;
        check_val("req_valid", 32'(imem_req_valid), 32'(e_rv));
        check_val("req_addr", imem_req_addr, model_pc);
        check_val("id_valid", 32'(id_valid), 32'(e_iv));
        check_val("id_pc", id_pc, e_pc);
        check_val("id_inst", id_inst, e_inst);
        if (dir_cap > 0 && id_valid) begin
            check_val("directed_pc", id_pc, dir_exp);
            dir_exp = dir_exp + 32'd4;
            dir_cap--;
        end
        if (w_on && w_id_valid && w_seen < 3) begin
            check_val("wrap_pc", w_id_pc, w_exp[w_seen]);
            check_val("wrap_inst", w_id_inst, w_exp[w_seen]);
            w_seen++;
        end
        w_fire_prev = w_req_valid && w_req_ready;
        w_addr_prev = w_req_addr;
        fire = e_rv && imem_req_ready;
        popd = e_iv && id_ready && !redirect_en;
        if (e_iv) last_pc = bufq[0].pc;
        if (rsp_now) e = pend.pop_front();
        if (redirect_en) begin
            foreach (pend[i]) pend[i].dead = 1'b1;
            bufq.delete();
            model_pc = {redirect_pc[31:2], 2'b00};
        end else begin
            if (popd) void'(bufq.pop_front());
            if (rsp_now && !e.dead) bufq.push_back('{e.addr, imem_rsp_data});
            if (fire) begin
                pend.push_back('{model_pc, cyc + lat, 1'b0});
                model_pc = model_pc + 32'd4;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Assert reset, check outputs in the same cycle, then release after two edges.
    task automatic do_reset();
        imem_rsp_valid = 1'b0;
        redirect_en    = 1'b0;
        id_ready       = 1'b0;
        imem_req_ready = 1'b0;
        w_rsp_valid    = 1'b0;
        w_fire_prev    = 1'b0;
        rst            = 1'b1;
        #1;
        check_val("rst_req_valid", 32'(imem_req_valid), 32'h0);
        check_val("rst_req_addr", imem_req_addr, 32'h0000_0000);
        check_val("rst_id_valid", 32'(id_valid), 32'h0);
        check_val("rst_id_inst", id_inst, NOP);
        check_val("rst_id_pc", id_pc, 32'h0000_0000);
        check_val("rst_wrap_pc", w_id_pc, 32'hFFFF_FFF8);
        pend.delete();
        bufq.delete();
        model_pc = 32'h0000_0000;
        last_pc  = 32'h0000_0000;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        bit hit6;
        w_exp[0] = 32'hFFFF_FFF8;
        w_exp[1] = 32'hFFFF_FFFC;
        w_exp[2] = 32'h0000_0000;
        key = 32'h0; lat = 1; p_ready = 100; p_rsp = 100; p_idr = 100; p_redir = 0;
        redir_once = 1'b0; redir_on_rsp = 1'b0; redir_hit = 1'b0; redir_once_pc = 32'h0;
        dir_cap = 0; dir_exp = 32'h0; w_on = 1'b1; w_seen = 0; w_addr_prev = 32'h0;
        model_pc = 32'h0; last_pc = 32'h0;
        #1;
        do_reset();

        // Streaming with a 1-cycle memory returning the address as data
        repeat (30) cycle();
        w_on = 1'b0;
        check_val("wrap_seen", 32'(w_seen), 32'd3);

        // ID stall: buffer fills, requests stop, then drains in order
        key   = 32'h5A5A_C3C3;
        p_idr = 0;
        repeat (10) cycle();
        check_val("stall_req_off", 32'(imem_req_valid), 32'h0);
        check_val("stall_id_valid", 32'(id_valid), 32'h1);
        p_idr = 100;
        repeat (10) cycle();

        // Two requests in flight on a 3-cycle memory, then redirect to an unaligned target
        do_reset();
        lat = 3;
        repeat (2) cycle();
        redir_once    = 1'b1;
        redir_once_pc = 32'h0000_0103;
        dir_cap       = 2;
        dir_exp       = 32'h0000_0100;
        repeat (25) cycle();
        check_val("redirect_seen", 32'(dir_cap), 32'h0);

        // Redirect coinciding with a response and an ID handshake
        lat          = 1;
        redir_on_rsp = 1'b1;
        redir_hit    = 1'b0;
        repeat (40) cycle();
        check_val("redirect_collide_hit", 32'(redir_hit), 32'h1);

        // Random traffic
        p_ready = 70; p_rsp = 70; p_idr = 60; p_redir = 8;
        for (int blk = 0; blk < 8; blk++) begin
            lat = $urandom_range(3, 1);
            repeat (50) cycle();
        end

        // Reset in the middle of traffic, then refetch from the reset PC
        p_ready = 100; p_rsp = 100; p_redir = 0; p_idr = 0; lat = 3;
        hit6 = 1'b0;
        for (int i = 0; i < 40 && !hit6; i++) begin
            cycle();
            if (pend.size() >= 1 && bufq.size() >= 1) hit6 = 1'b1;
        end
        check_val("midop_setup", 32'(hit6), 32'h1);
        do_reset();
        p_idr   = 100;
        dir_cap = 2;
        dir_exp = 32'h0000_0000;
        repeat (20) cycle();
        check_val("refetch_seen", 32'(dir_cap), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
